sseg_score_counter: RTL and testbench

- Upstream feeder for sseg_controller.
- Holds a saturating decimal score in the range 0..MAX_VAL.
- Accepts add/subtract requests over a valid/ready handshake.
- Drives sseg_controller's num, dig_en and dp_en inputs directly, with leading-zero blanking.
- Sits between game/console logic and the 4-digit seven-segment display.

---
 rtl/sseg_pkg.sv | 23 ++
 rtl/sseg_blink_timer.sv | 37 +++
 rtl/sseg_score_counter.sv | 191 +++++++++++++++++++
 tb/tb_sseg_score_counter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared constants and types for the seven-segment score counter slice.
package sseg_pkg;

    localparam int SSEG_DIGITS = 4;
    localparam int NUM_W       = 14;
    localparam int MAX_DEC     = 9999;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        MASK  = 2'd2
    } state_t;

    localparam logic [SSEG_DIGITS-1:0] MASK_4D = 4'b1111;
    localparam logic [SSEG_DIGITS-1:0] MASK_3D = 4'b0111;
    localparam logic [SSEG_DIGITS-1:0] MASK_2D = 4'b0011;
    localparam logic [SSEG_DIGITS-1:0] MASK_1D = 4'b0001;

    localparam int DEC_1000 = 1000;
    localparam int DEC_100  = 100;
    localparam int DEC_10   = 10;

endpackage

// File: rtl/sseg_blink_timer.sv
// Blink phase generator for saturated scores; only built with SSEG_SCORE_BLINK_EN.
`ifdef SSEG_SCORE_BLINK_EN
module sseg_blink_timer #(
    parameter int DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic phase
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_r;
    logic          phase_r;

    // Half-period counter; held at zero when disabled or restarted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r   <= {CW{1'b0}};
            phase_r <= 1'b0;
        end else if (!en || restart) begin
            cnt_r   <= {CW{1'b0}};
            phase_r <= 1'b0;
        end else if (cnt_r == CW'(DIV - 1)) begin
            cnt_r   <= {CW{1'b0}};
            phase_r <= ~phase_r;
        end else begin
            cnt_r   <= cnt_r + CW'(1);
        end
    end

    assign phase = phase_r;

endmodule
`endif

// File: rtl/sseg_score_counter.sv
// Saturating decimal score with add/subtract handshake feeding sseg_controller.
// Optional saturation blink enabled by defining SSEG_SCORE_BLINK_EN.
module sseg_score_counter
    import sseg_pkg::*;
#(
    parameter int MAX_VAL   = sseg_pkg::MAX_DEC,
    parameter int NUM_W     = sseg_pkg::NUM_W,
    parameter int VAL_W     = 8,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   inc_valid,
    output logic                   inc_ready,
    input  logic                   inc_op,
    input  logic [VAL_W-1:0]       inc_val,
    output logic [NUM_W-1:0]       num,
    output logic [SSEG_DIGITS-1:0] dig_en,
    output logic [SSEG_DIGITS-1:0] dp_en,
    output logic                   sat
);

    localparam int               W1       = NUM_W + 1;
    localparam logic [W1-1:0]    MAX_EXT  = W1'(MAX_VAL);
    localparam logic [NUM_W-1:0] THR_1000 = NUM_W'(DEC_1000);
    localparam logic [NUM_W-1:0] THR_100  = NUM_W'(DEC_100);
    localparam logic [NUM_W-1:0] THR_10   = NUM_W'(DEC_10);

    state_t                   state_r;
    state_t                   state_nxt_s;
    logic                     accept_s;
    logic                     pend_op_r;
    logic [VAL_W-1:0]         pend_val_r;
    logic [NUM_W-1:0]         num_r;
    logic                     sat_r;
    logic [SSEG_DIGITS-1:0]   dig_mask_r;
    logic [SSEG_DIGITS-1:0]   mask_s;
    logic [W1-1:0]            sum_s;
    logic [NUM_W-1:0]         res_s;
    logic                     res_sat_s;

    assign inc_ready = (state_r == IDLE) && !clr;

    // FSM state register; clr forces IDLE from any state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else if (clr) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (inc_valid && inc_ready) begin
                    accept_s    = 1'b1;
                    state_nxt_s = APPLY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            APPLY:   state_nxt_s = MASK;
            MASK:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Pending request captured on handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_op_r  <= 1'b0;
            pend_val_r <= {VAL_W{1'b0}};
        end else if (accept_s) begin
            pend_op_r  <= inc_op;
            pend_val_r <= inc_val;
        end else begin
            pend_op_r  <= pend_op_r;
            pend_val_r <= pend_val_r;
        end
    end

    // Saturating add/subtract, one bit wider so overflow is visible
    always_comb begin
        sum_s     = {1'b0, num_r} + W1'(pend_val_r);
        res_s     = num_r;
        res_sat_s = 1'b0;
        if (pend_op_r) begin
            if (W1'(pend_val_r) > {1'b0, num_r}) begin
                res_s     = {NUM_W{1'b0}};
                res_sat_s = 1'b1;
            end else begin
                res_s     = num_r - NUM_W'(pend_val_r);
                res_sat_s = 1'b0;
            end
        end else begin
            if (sum_s > MAX_EXT) begin
                res_s     = MAX_EXT[NUM_W-1:0];
                res_sat_s = 1'b1;
            end else begin
                res_s     = sum_s[NUM_W-1:0];
                res_sat_s = 1'b0;
            end
        end
    end

    // Score and saturation flag, updated in APPLY
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            num_r <= {NUM_W{1'b0}};
            sat_r <= 1'b0;
        end else if (clr) begin
            num_r <= {NUM_W{1'b0}};
            sat_r <= 1'b0;
        end else if (state_r == APPLY) begin
            num_r <= res_s;
            sat_r <= res_sat_s;
        end else begin
            num_r <= num_r;
            sat_r <= sat_r;
        end
    end

    // Leading-zero blanking: the units digit is always lit
    always_comb begin
        mask_s = MASK_1D;
        if (num_r >= THR_1000) begin
            mask_s = MASK_4D;
        end else if (num_r >= THR_100) begin
            mask_s = MASK_3D;
        end else if (num_r >= THR_10) begin
            mask_s = MASK_2D;
        end else begin
            mask_s = MASK_1D;
        end
    end

    // Digit mask register, refreshed in MASK
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dig_mask_r <= MASK_1D;
        end else if (clr) begin
            dig_mask_r <= MASK_1D;
        end else if (state_r == MASK) begin
            dig_mask_r <= mask_s;
        end else begin
            dig_mask_r <= dig_mask_r;
        end
    end

    assign num   = num_r;
    assign sat   = sat_r;
    assign dp_en = 4'b0000;

`ifdef SSEG_SCORE_BLINK_EN
    logic sat_prev_r;
    logic phase_s;

    // Previous sat, used to restart the blink phase on a rising edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_prev_r <= 1'b0;
        end else if (clr) begin
            sat_prev_r <= 1'b0;
        end else begin
            sat_prev_r <= sat_r;
        end
    end

    sseg_blink_timer #(
        .DIV (BLINK_DIV)
    ) u_blink (
        .clk     (clk),
        .rst     (rst),
        .en      (sat_r),
        .restart (sat_r & ~sat_prev_r),
        .phase   (phase_s)
    );

    assign dig_en = (sat_r && phase_s) ? 4'b0000 : dig_mask_r;
`else
    assign dig_en = dig_mask_r;
`endif

endmodule

// File: tb/tb_sseg_score_counter.sv
// Directed bench for sseg_score_counter: vector table plus multi-cycle corner sequences.
module tb_sseg_score_counter;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        inc_valid;
    logic        inc_ready;
    logic        inc_op;
    logic [7:0]  inc_val;
    logic [13:0] num;
    logic [3:0]  dig_en;
    logic [3:0]  dp_en;
    logic        sat;

    int errors = 0;
    int checks = 0;
    int prev_num;
    logic [3:0] prev_dig;

    typedef struct {
        logic       op;
        logic [7:0] val;
        int         en;
        logic       es;
        logic [3:0] ed;
    } vec_t;

    vec_t vecs [14];

    sseg_score_counter dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .inc_valid (inc_valid),
        .inc_ready (inc_ready),
        .inc_op    (inc_op),
        .inc_val   (inc_val),
        .num       (num),
        .dig_en    (dig_en),
        .dp_en     (dp_en),
        .sat       (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] mask_of(input int n);
        if (n >= 1000)     return 4'b1111;
        else if (n >= 100) return 4'b0111;
        else if (n >= 10)  return 4'b0011;
        else               return 4'b0001;
    endfunction

    task automatic run_op(input string nm, input logic op, input logic [7:0] val,
                          input int en, input logic es, input logic [3:0] ed);
        int w;
        w = 0;
        while (!inc_ready && w < 10) begin
            tick();
            w++;
        end
        chk({nm, "_ready_wait"}, 32'(inc_ready), 32'd1);
        inc_valid = 1'b1;
        inc_op    = op;
        inc_val   = val;
        tick();
        inc_valid = 1'b0;
        inc_val   = 8'd0;
        chk({nm, "_rdy_n1"}, 32'(inc_ready), 32'd0);
        chk({nm, "_num_n1"}, 32'(num), 32'(prev_num));
        tick();
        chk({nm, "_rdy_n2"}, 32'(inc_ready), 32'd0);
        chk({nm, "_num"},    32'(num), 32'(en));
        chk({nm, "_sat"},    32'(sat), 32'(es));
        chk({nm, "_dig_n2"}, 32'(dig_en), 32'(prev_dig));
        tick();
        chk({nm, "_rdy_n3"}, 32'(inc_ready), 32'd1);
        chk({nm, "_dig"},    32'(dig_en), 32'(ed));
        prev_num = en;
        prev_dig = ed;
    endtask

    task automatic do_clr(input string nm);
        clr = 1'b1;
        #1;
        chk({nm, "_rdy_in_clr"}, 32'(inc_ready), 32'd0);
        tick();
        clr = 1'b0;
        #1;
        chk({nm, "_num"},   32'(num), 32'd0);
        chk({nm, "_dig"},   32'(dig_en), 32'd1);
        chk({nm, "_sat"},   32'(sat), 32'd0);
        chk({nm, "_ready"}, 32'(inc_ready), 32'd1);
        prev_num = 0;
        prev_dig = 4'b0001;
    endtask

    initial begin
        int acc;
        int accepts;
        logic [3:0] m;

        vecs[0]  = '{1'b0, 8'd200, 200, 1'b0, 4'b0111};
        vecs[1]  = '{1'b0, 8'd0,   200, 1'b0, 4'b0111};
        vecs[2]  = '{1'b1, 8'd195, 5,   1'b0, 4'b0001};
        vecs[3]  = '{1'b1, 8'd7,   0,   1'b1, 4'b0001};
        vecs[4]  = '{1'b0, 8'd15,  15,  1'b0, 4'b0011};
        vecs[5]  = '{1'b1, 8'd6,   9,   1'b0, 4'b0001};
        vecs[6]  = '{1'b0, 8'd91,  100, 1'b0, 4'b0111};
        vecs[7]  = '{1'b1, 8'd1,   99,  1'b0, 4'b0011};
        vecs[8]  = '{1'b0, 8'd255, 354, 1'b0, 4'b0111};
        vecs[9]  = '{1'b1, 8'd255, 99,  1'b0, 4'b0011};
        vecs[10] = '{1'b1, 8'd99,  0,   1'b0, 4'b0001};
        vecs[11] = '{1'b1, 8'd0,   0,   1'b0, 4'b0001};
        vecs[12] = '{1'b1, 8'd255, 0,   1'b1, 4'b0001};
        vecs[13] = '{1'b0, 8'd255, 255, 1'b0, 4'b0111};

        rst       = 1'b0;
        clr       = 1'b0;
        inc_valid = 1'b0;
        inc_op    = 1'b0;
        inc_val   = 8'd0;
        prev_num  = 0;
        prev_dig  = 4'b0001;

        // Reset
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_num",   32'(num), 32'd0);
        chk("rst_dig",   32'(dig_en), 32'd1);
        chk("rst_dp",    32'(dp_en), 32'd0);
        chk("rst_sat",   32'(sat), 32'd0);
        chk("rst_ready", 32'(inc_ready), 32'd1);
        tick();

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].val,
                   vecs[i].en, vecs[i].es, vecs[i].ed);
        end

        // Back-to-back requests with valid held high
        do_clr("clr1");
        accepts = 0;
        inc_valid = 1'b1;
        inc_op    = 1'b0;
        inc_val   = 8'd1;
        for (int c = 0; c < 30; c++) begin
            if (inc_ready) accepts++;
            tick();
        end
        inc_valid = 1'b0;
        inc_val   = 8'd0;
        chk("b2b_accepts", 32'(accepts), 32'd10);
        chk("b2b_num",     32'(num), 32'd10);
        chk("b2b_dig",     32'(dig_en), 32'd3);
        prev_num = 10;
        prev_dig = 4'b0011;

        // clr while an add is in APPLY
        do_clr("clr2");
        run_op("set100", 1'b0, 8'd100, 100, 1'b0, 4'b0111);
        inc_valid = 1'b1;
        inc_op    = 1'b0;
        inc_val   = 8'd50;
        tick();
        inc_valid = 1'b0;
        inc_val   = 8'd0;
        do_clr("clr_apply");
        tick();
        tick();
        chk("clr_apply_lost_num", 32'(num), 32'd0);
        chk("clr_apply_lost_dig", 32'(dig_en), 32'd1);

        // Climb to 9900 then saturate at the top
        acc = 0;
        for (int k = 0; k < 38; k++) begin
            acc = acc + 255;
            m = mask_of(acc);
            run_op($sformatf("climb%0d", k), 1'b0, 8'd255, acc, 1'b0, m);
        end
        run_op("to9900",  1'b0, 8'd210, 9900, 1'b0, 4'b1111);
        run_op("sat_hi",  1'b0, 8'd255, 9999, 1'b1, 4'b1111);
        run_op("add0",    1'b0, 8'd0,   9999, 1'b0, 4'b1111);
        run_op("sat_hi1", 1'b0, 8'd1,   9999, 1'b1, 4'b1111);
        run_op("sub1",    1'b1, 8'd1,   9998, 1'b0, 4'b1111);
        run_op("add1",    1'b0, 8'd1,   9999, 1'b0, 4'b1111);

        // Asynchronous reset in the middle of an operation
        inc_valid = 1'b1;
        inc_op    = 1'b1;
        inc_val   = 8'd255;
        tick();
        inc_valid = 1'b0;
        inc_val   = 8'd0;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_num",   32'(num), 32'd0);
        chk("arst_dig",   32'(dig_en), 32'd1);
        chk("arst_sat",   32'(sat), 32'd0);
        chk("arst_ready", 32'(inc_ready), 32'd1);
        #2;
        rst = 1'b1;
        tick();
        tick();
        tick();
        chk("arst_after_num", 32'(num), 32'd0);
        chk("arst_after_dig", 32'(dig_en), 32'd1);
        prev_num = 0;
        prev_dig = 4'b0001;
        run_op("post_rst", 1'b0, 8'd42, 42, 1'b0, 4'b0011);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
